// File: rtl/sm4_engine_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sm4_engine_arbiter
//  Description : Round-robin arbiter sharing one iterative SM4 round engine
//                between NUM_REQ requesters, with tagged response and watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module sm4_engine_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 48
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_text,
    input  logic [NUM_REQ*128-1:0] req_key,
    output logic                   eng_in_valid,
    output logic [127:0]           eng_plaintext,
    output logic [127:0]           eng_key,
    input  logic                   eng_out_valid,
    input  logic [127:0]           eng_result,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [127:0]           resp_data,
    output logic                   resp_err,
    output logic                   busy
);

    localparam logic [7:0]      WD_LAST   = 8'(TIMEOUT_CYC - 1);
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_rr_ptr;
    logic [7:0]      r_wd_cnt;
    logic [127:0]    r_text;
    logic [127:0]    r_key;
    logic [127:0]    r_data;
    logic [ID_W-1:0] r_id;
    logic            r_err;

    logic [ID_W:0]   w_idx [NUM_REQ];
    logic            w_found;
    logic [ID_W-1:0] w_gnt;
    logic [ID_W-1:0] w_ptr_nxt;
    logic            w_grant;
    logic            w_run_done;
    logic            w_timeout;

    // Candidate index for each search offset, wrapped modulo NUM_REQ.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx[k] = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx[k] >= NUM_REQ_W) begin
                w_idx[k] = w_idx[k] - NUM_REQ_W;
            end
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[w_idx[k][ID_W-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[k][ID_W-1:0];
            end
        end
    end

    assign w_ptr_nxt  = (w_gnt == LAST_ID) ? '0 : w_gnt + 1'b1;
    assign w_grant    = (r_state == ST_IDLE) && w_found;
    assign w_timeout  = (r_wd_cnt == WD_LAST);
    assign w_run_done = eng_out_valid || w_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = '0;
        eng_in_valid = 1'b0;
        resp_valid   = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_found) begin
                    // Gated so no accept pulse leaks out while reset is held.
                    req_ready[w_gnt] = reset_n;
                    w_state_nxt      = ST_RUN;
                end
            end
            ST_RUN: begin
                eng_in_valid = 1'b1;
                if (w_run_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
            r_wd_cnt <= '0;
            r_text   <= '0;
            r_key    <= '0;
            r_id     <= '0;
            r_data   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_wd_cnt <= (r_state == ST_RUN) ? r_wd_cnt + 8'd1 : 8'd0;
            if (w_grant) begin
                r_text   <= req_text[int'(w_gnt)*128 +: 128];
                r_key    <= req_key[int'(w_gnt)*128 +: 128];
                r_id     <= w_gnt;
                r_rr_ptr <= w_ptr_nxt;
            end
            // A strobe landing on the timeout cycle still delivers its result.
            if (r_state == ST_RUN) begin
                if (eng_out_valid) begin
                    r_data <= eng_result;
                    r_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_data <= '0;
                    r_err  <= 1'b1;
                end
            end
        end
    end

    assign eng_plaintext = r_text;
    assign eng_key       = r_key;
    assign resp_id       = r_id;
    assign resp_data     = r_data;
    assign resp_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sm4_engine_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm4_engine_arbiter
//  Description : Randomized self-checking bench with engine model and
//                scoreboard-based reference of the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sm4_engine_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ID_W        = 2;
    localparam int TIMEOUT_CYC = 48;
    localparam logic [127:0] KAT_PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KAT_CT = 128'h681edf34d206965e86b3e94f536e4246;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_text = '0;
    logic [NUM_REQ*128-1:0] req_key = '0;
    logic                   eng_in_valid;
    logic [127:0]           eng_plaintext;
    logic [127:0]           eng_key;
    logic                   eng_out_valid;
    logic [127:0]           eng_result;
    logic                   resp_valid;
    logic                   resp_ready = 1'b0;
    logic [ID_W-1:0]        resp_id;
    logic [127:0]           resp_data;
    logic                   resp_err;
    logic                   busy;

    sm4_engine_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ID_W       (ID_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_text     (req_text),
        .req_key      (req_key),
        .eng_in_valid (eng_in_valid),
        .eng_plaintext(eng_plaintext),
        .eng_key      (eng_key),
        .eng_out_valid(eng_out_valid),
        .eng_result   (eng_result),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Engine stand-in: known-answer vector for the reference pair, cheap mix otherwise.
    function automatic logic [127:0] eng_fn(input logic [127:0] pt, input logic [127:0] k);
        if (pt == KAT_PT && k == KAT_PT) return KAT_CT;
        return pt ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_a5a5_f0f0_1234_5678_9abc_def0;
    endfunction

    int   run_cycles = 0;
    int   eng_lat    = 32;
    bit   eng_mute   = 1'b0;
    bit   stray      = 1'b0;
    int   cyc        = 0;

    always @(posedge clk) begin
        run_cycles <= eng_in_valid ? run_cycles + 1 : 0;
        cyc        <= cyc + 1;
    end

    assign eng_out_valid = stray || (eng_in_valid && !eng_mute && run_cycles == eng_lat - 1);
    assign eng_result    = stray ? 128'hdead_beef : eng_fn(eng_plaintext, eng_key);

    // Reference: jobs in flight with their grant cycle and expected run length.
    typedef struct {
        int           id;
        logic [127:0] text;
        logic [127:0] key;
        int           gcyc;
        int           lat;
        bit           err;
    } job_t;

    job_t               q[$];
    int                 grant_log[$];
    job_t               job;
    int                 model_ptr   = 0;
    int                 gap_cyc     = -1;
    int                 last_hs_cyc = -1;
    int                 hs_count    = 0;
    bit                 gap_chk     = 1'b0;
    int                 mon_g;
    bit                 mon_idle;
    bit                 mon_run;
    bit                 mon_resp;
    logic [NUM_REQ-1:0] mon_rdy;
    logic [127:0]       last_data;
    logic [ID_W-1:0]    last_id;
    logic               last_err;

    always @(negedge clk) begin
        if (!reset_n) begin
            model_ptr = 0;
            q.delete();
            gap_cyc     = -1;
            last_hs_cyc = -1;
        end else begin
            mon_idle = (q.size() == 0) && (cyc != gap_cyc);
            check_eq("busy", 128'(busy), 128'(!mon_idle));
            check_eq("ready_onehot", 128'($countones(req_ready) <= 1), 128'(1));
            mon_g = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (mon_g < 0 && req_valid[(model_ptr + k) % NUM_REQ]) mon_g = (model_ptr + k) % NUM_REQ;
            end
            mon_rdy = '0;
            if (mon_idle && mon_g >= 0) mon_rdy[mon_g] = 1'b1;
            check_eq("req_ready", 128'(req_ready), 128'(mon_rdy));
            if (mon_idle && mon_g >= 0) begin
                job.id   = mon_g;
                job.text = req_text[128*mon_g +: 128];
                job.key  = req_key[128*mon_g +: 128];
                job.gcyc = cyc;
                job.err  = eng_mute || (eng_lat > TIMEOUT_CYC);
                job.lat  = job.err ? TIMEOUT_CYC : eng_lat;
                q.push_back(job);
                grant_log.push_back(mon_g);
                if (gap_chk && last_hs_cyc >= 0) check_eq("grant_gap", 128'(cyc - last_hs_cyc), 128'(2));
                model_ptr = (mon_g + 1) % NUM_REQ;
            end
            mon_run  = 1'b0;
            mon_resp = 1'b0;
            if (q.size() > 0) begin
                mon_run  = (cyc > q[0].gcyc) && (cyc <= q[0].gcyc + q[0].lat);
                mon_resp = (cyc > q[0].gcyc + q[0].lat);
            end
            check_eq("eng_in_valid", 128'(eng_in_valid), 128'(mon_run));
            if (mon_run) begin
                check_eq("eng_plaintext", eng_plaintext, q[0].text);
                check_eq("eng_key", eng_key, q[0].key);
            end
            check_eq("resp_valid", 128'(resp_valid), 128'(mon_resp));
            if (mon_resp) begin
                check_eq("resp_id", 128'(resp_id), 128'(q[0].id));
                check_eq("resp_err", 128'(resp_err), 128'(q[0].err));
                check_eq("resp_data", resp_data, q[0].err ? 128'd0 : eng_fn(q[0].text, q[0].key));
                if (resp_ready) begin
                    last_data   = resp_data;
                    last_id     = resp_id;
                    last_err    = resp_err;
                    void'(q.pop_front());
                    hs_count++;
                    gap_cyc     = cyc + 1;
                    last_hs_cyc = cyc;
                end
            end
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin
            step();
            n++;
        end
        check_eq("hs_wait", 128'(hs_count), 128'(target));
    endtask

    task automatic drain();
        int n = 0;
        req_valid  = '0;
        resp_ready = 1'b1;
        while (q.size() > 0 && n < 400) begin
            step();
            n++;
        end
        check_eq("drain", 128'(q.size()), 128'(0));
        step();
        step();
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        stray      = 1'b0;
        step();
        step();
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_eng_in_valid", 128'(eng_in_valid), 128'(0));
        check_eq("rst_resp_valid", 128'(resp_valid), 128'(0));
        check_eq("rst_resp_data", resp_data, 128'd0);
        check_eq("rst_resp_err", 128'(resp_err), 128'(0));
        check_eq("rst_resp_id", 128'(resp_id), 128'(0));
        check_eq("rst_eng_plaintext", eng_plaintext, 128'd0);
        check_eq("rst_eng_key", eng_key, 128'd0);
        grant_log.delete();
        hs_count = 0;
        reset_n  = 1'b1;
        step();
    endtask

    initial begin
        logic [127:0] snap;
        int           n;
        do_reset();

        // Single requester, known-answer vector; valid dropped right after grant.
        eng_lat    = 32;
        resp_ready = 1'b1;
        req_text[128*1 +: 128] = KAT_PT;
        req_key[128*1 +: 128]  = KAT_PT;
        req_valid = 4'b0010;
        n = 0;
        while (grant_log.size() == 0 && n < 20) begin step(); n++; end
        req_valid = '0;
        wait_hs(1, 100);
        check_eq("t1_id", 128'(last_id), 128'(1));
        check_eq("t1_data", last_data, KAT_CT);
        check_eq("t1_err", 128'(last_err), 128'(0));
        drain();

        // All requesters valid from reset: strict rotation.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_text[128*i +: 128] = rnd128();
            req_key[128*i +: 128]  = rnd128();
        end
        gap_chk    = 1'b1;
        resp_ready = 1'b1;
        req_valid  = 4'hf;
        wait_hs(8, 8 * 50);
        req_valid = '0;
        gap_chk   = 1'b0;
        drain();
        check_eq("t2_count", 128'(grant_log.size() >= 8), 128'(1));
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            check_eq("t2_order", 128'(grant_log[i]), 128'(i % NUM_REQ));
        end

        // Backpressure: response held, no new grant, stray strobe ignored.
        eng_lat    = 20;
        resp_ready = 1'b0;
        req_text[128*3 +: 128] = rnd128();
        req_key[128*3 +: 128]  = rnd128();
        req_valid = 4'b1000;
        n = 0;
        while (!resp_valid && n < 100) begin step(); n++; end
        check_eq("t3_resp_valid", 128'(resp_valid), 128'(1));
        snap      = resp_data;
        req_valid = 4'b0111;
        for (int i = 0; i < 10; i++) begin
            stray = (i == 4);
            step();
            check_eq("t3_hold_valid", 128'(resp_valid), 128'(1));
            check_eq("t3_hold_data", resp_data, snap);
            check_eq("t3_eng_idle", 128'(eng_in_valid), 128'(0));
        end
        stray      = 1'b0;
        resp_ready = 1'b1;
        wait_hs(hs_count + 1, 10);
        req_valid = '0;
        check_eq("t3_id", 128'(last_id), 128'(3));
        drain();

        // Engine never answers: watchdog abort.
        eng_mute = 1'b1;
        req_text[0 +: 128] = rnd128();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        wait_hs(hs_count + 1, 100);
        check_eq("t4_err", 128'(last_err), 128'(1));
        check_eq("t4_data", last_data, 128'd0);
        eng_mute = 1'b0;
        drain();

        // Strobe on the timeout cycle: result wins.
        eng_lat = TIMEOUT_CYC;
        req_text[128*2 +: 128] = rnd128();
        req_key[128*2 +: 128]  = rnd128();
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        wait_hs(hs_count + 1, 100);
        check_eq("t5_err", 128'(last_err), 128'(0));
        check_eq("t5_data", last_data, eng_fn(req_text[128*2 +: 128], req_key[128*2 +: 128]));
        drain();

        // Randomized traffic, latency fixed per batch.
        for (int b = 0; b < 4; b++) begin
            eng_lat  = (b == 3) ? 50 : int'($urandom_range(1, 40));
            eng_mute = (b == 2);
            for (int c = 0; c < 150; c++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_text[128*i +: 128] = rnd128();
                    req_key[128*i +: 128]  = rnd128();
                end
                req_valid  = NUM_REQ'($urandom);
                resp_ready = ($urandom_range(0, 3) != 0);
                step();
            end
            drain();
            eng_mute = 1'b0;
        end

        // Reset in the middle of a run.
        eng_lat   = 32;
        req_valid = 4'b0100;
        n = 0;
        while (run_cycles != 10 && n < 60) begin step(); n++; end
        check_eq("t6_reach_run", 128'(run_cycles), 128'(10));
        req_valid = '0;
        reset_n   = 1'b0;
        #1;
        check_eq("t6_busy", 128'(busy), 128'(0));
        check_eq("t6_eng_in_valid", 128'(eng_in_valid), 128'(0));
        check_eq("t6_resp_valid", 128'(resp_valid), 128'(0));
        step();
        reset_n = 1'b1;
        grant_log.delete();
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t6_no_resp", 128'(resp_valid), 128'(0));
        end
        req_valid = 4'hf;
        n = 0;
        while (grant_log.size() == 0 && n < 10) begin step(); n++; end
        req_valid = '0;
        check_eq("t6_grant_seen", 128'(grant_log.size()), 128'(1));
        if (grant_log.size() > 0) check_eq("t6_rr_ptr_zero", 128'(grant_log[0]), 128'(0));
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
